// File: rtl/code_pkg.sv
// Shared symbol encoding and sender FSM state encoding for the code sender and detector.
package code_pkg;

  localparam logic [1:0] SYM_TOP   = 2'b00;
  localparam logic [1:0] SYM_DOWN  = 2'b01;
  localparam logic [1:0] SYM_LEFT  = 2'b10;
  localparam logic [1:0] SYM_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Button vector bit order: [0]=top, [1]=down, [2]=left, [3]=right.
  function automatic logic [3:0] sym_onehot(input logic [1:0] sym);
    logic [3:0] v;
    v = '0;
    case (sym)
      SYM_TOP:   v = 4'b0001;
      SYM_DOWN:  v = 4'b0010;
      SYM_LEFT:  v = 4'b0100;
      SYM_RIGHT: v = 4'b1000;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sym_decode.sv
// Converts a 2-bit symbol plus enable into a one-hot (or all-zero) button vector.
module sym_decode
  import code_pkg::*;
(
  input  logic [1:0] i_sym,
  input  logic       i_en,
  output logic [3:0] o_btn
);

  always_comb begin
    o_btn = '0;
    if (i_en) o_btn = sym_onehot(i_sym);
  end

endmodule

// File: rtl/code_sender.sv
// Replays a latched sequence of direction symbols as timed pulses on four button lines.
module code_sender
  import code_pkg::*;
#(
  parameter int CODE_LEN     = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  buttonReset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2*CODE_LEN-1:0] code,
  output logic                  buttonTop,
  output logic                  buttonDown,
  output logic                  buttonLeft,
  output logic                  buttonRight,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned IW     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(CODE_LEN - 1);

  if (CODE_LEN < 1 || PULSE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("code_sender: CODE_LEN, PULSE_CYCLES and GAP_CYCLES must each be >= 1");
  end

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [PW-1:0]         r_phase, w_phase_nxt;
  logic [2*CODE_LEN-1:0] r_code, w_code_nxt;
  logic [3:0]            r_btn;
  logic                  r_busy, r_done;
  logic [2*CODE_LEN-1:0] w_code_sh;
  logic [3:0]            w_btn_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_code_nxt  = r_code;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_PULSE;
          w_code_nxt  = code;
          w_idx_nxt   = '0;
          w_phase_nxt = '0;
        end
      end
      ST_PULSE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_phase_nxt = '0;
        end else if (r_phase == PULSE_LAST) begin
          w_state_nxt = ST_GAP;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_phase_nxt = '0;
        end else if (r_phase == GAP_LAST) begin
          w_phase_nxt = '0;
          if (r_idx < IDX_LAST) begin
            w_state_nxt = ST_PULSE;
            w_idx_nxt   = r_idx + 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered buttons line up with the state.
  assign w_code_sh = w_code_nxt >> {w_idx_nxt, 1'b0};

  sym_decode u_sym_decode (
    .i_sym (w_code_sh[1:0]),
    .i_en  (w_state_nxt == ST_PULSE),
    .o_btn (w_btn_nxt)
  );

  always_ff @(posedge clk or negedge buttonReset_n) begin
    if (!buttonReset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_phase <= '0;
      r_code  <= '0;
      r_btn   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
      r_code  <= w_code_nxt;
      r_btn   <= w_btn_nxt;
      r_busy  <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_GAP);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign buttonTop   = r_btn[0];
  assign buttonDown  = r_btn[1];
  assign buttonLeft  = r_btn[2];
  assign buttonRight = r_btn[3];
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_code_sender.sv
// Bench for code_sender: default-timed and slow-timed instances checked against a cycle-offset model.
module tb_code_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] code;
  logic       top_a, down_a, left_a, right_a, busy_a, done_a;
  logic       top_b, down_b, left_b, right_b, busy_b, done_b;
  logic [3:0] btn_a, btn_b;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         run = 1'b0;

  assign btn_a = {right_a, left_a, down_a, top_a};
  assign btn_b = {right_b, left_b, down_b, top_b};

  always #5 clk = ~clk;

  code_sender u_dut_a (
    .clk(clk), .buttonReset_n(rst_n), .start(start_a), .abort(abort_a), .code(code),
    .buttonTop(top_a), .buttonDown(down_a), .buttonLeft(left_a), .buttonRight(right_a),
    .busy(busy_a), .done(done_a)
  );

  code_sender #(.CODE_LEN(4), .PULSE_CYCLES(3), .GAP_CYCLES(2)) u_dut_b (
    .clk(clk), .buttonReset_n(rst_n), .start(start_b), .abort(abort_b), .code(code),
    .buttonTop(top_b), .buttonDown(down_b), .buttonLeft(left_b), .buttonRight(right_b),
    .busy(busy_b), .done(done_b)
  );

  // Expected {done, busy, btn[3:0]} in cycle t after the start edge of an unaborted send.
  function automatic logic [5:0] model(input logic [7:0] c, input int p, input int g, input int t);
    int n, k, r;
    logic [7:0] sh;
    logic [5:0] m;
    m = '0;
    n = 4 * (p + g);
    if (t >= 1 && t <= n) begin
      k = (t - 1) / (p + g);
      r = (t - 1) % (p + g);
      m[4] = 1'b1;
      if (r < p) begin
        sh = c >> (2 * k);
        m[3:0] = 4'b0001 << sh[1:0];
      end
    end
    if (t == n + 1) m[5] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input bit sel, input logic [5:0] exp, input string what);
    logic [5:0] obs;
    obs = sel ? {done_b, busy_b, btn_b} : {done_a, busy_a, btn_a};
    chk($sformatf("%s dut%0d buttons", what, sel), {4'h0, obs[3:0]}, {4'h0, exp[3:0]});
    chk($sformatf("%s dut%0d busy", what, sel), {7'h0, obs[4]}, {7'h0, exp[4]});
    chk($sformatf("%s dut%0d done", what, sel), {7'h0, obs[5]}, {7'h0, exp[5]});
  endtask

  task automatic drive(input bit sel, input logic s, input logic a);
    if (sel) begin start_b = s; abort_b = a; end
    else     begin start_a = s; abort_a = a; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call 1 time unit after an edge; that next edge samples start.
  task automatic run_send(input bit sel, input logic [7:0] c, input int abort_at,
                          input int bstart_at, input logic [7:0] bcode);
    int p, g, n;
    logic [5:0] e;
    p = sel ? 3 : 1;
    g = sel ? 2 : 1;
    n = 4 * (p + g);
    code = c;
    drive(sel, 1'b1, 1'b0);
    step();
    for (int t = 1; t <= n + 2; t++) begin
      e = (abort_at > 0 && abort_at < t) ? 6'h00 : model(c, p, g, t);
      check_dut(sel, e, $sformatf("send c=%0h t=%0d", c, t));
      check_dut(!sel, 6'h00, "bystander");
      code = (t == bstart_at) ? bcode : 8'($urandom);
      drive(sel, t == bstart_at, t == abort_at);
      step();
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      code = 8'($urandom);
      drive(1'b0, 1'b0, 1'($urandom));
      drive(1'b1, 1'b0, 1'($urandom));
      step();
      check_dut(1'b0, 6'h00, "idle");
      check_dut(1'b1, 6'h00, "idle");
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (run) begin
      n_cmp++;
      assert ($countones(btn_a) <= 1 && $countones(btn_b) <= 1) else begin
        n_bad++;
        $error("FAIL onehot: observed a=%b b=%b expected at most one high", btn_a, btn_b);
      end
      n_cmp++;
      assert (!(done_a && busy_a) && !(done_b && busy_b)) else begin
        n_bad++;
        $error("FAIL done_busy: observed a=%b%b b=%b%b expected not both", done_a, busy_a, done_b, busy_b);
      end
    end
  end

  initial begin
    int n, ab, bs;
    bit sel;
    logic [7:0] c;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    code = 8'hFF;
    #12;
    check_dut(1'b0, 6'h00, "reset");
    check_dut(1'b1, 6'h00, "reset");
    rst_n = 1'b1;
    step();
    run = 1'b1;

    // Basic sends at both timings.
    run_send(1'b0, 8'hE8, 0, 0, 8'h00);
    run_send(1'b1, 8'h1B, 0, 0, 8'h00);
    // Start while busy is not queued.
    run_send(1'b0, 8'hE8, 0, 4, 8'h00);
    // Abort in cycle 3, then a full resend.
    run_send(1'b0, 8'hE8, 3, 0, 8'h00);
    run_send(1'b0, 8'hE8, 0, 0, 8'h00);

    // Start together with abort in idle keeps the sender idle.
    code = 8'h55;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check_dut(1'b0, 6'h00, "start+abort");
    check_dut(1'b1, 6'h00, "start+abort");
    idle_cycles(2);

    // Asynchronous reset between edges 5 and 6.
    code = 8'hE8;
    drive(1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      check_dut(1'b0, model(8'hE8, 1, 1, t), $sformatf("pre-reset t=%0d", t));
      if (t < 5) step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_dut(1'b0, 6'h00, "in reset");
    step();
    check_dut(1'b0, 6'h00, "in reset");
    #3;
    rst_n = 1'b1;
    step();
    idle_cycles(3);
    run_send(1'b0, 8'hE8, 0, 0, 8'h00);

    // Randomized sends with random late starts and aborts.
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom);
      c = 8'($urandom);
      n = sel ? 20 : 8;
      ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, n)) : 0;
      bs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (ab > 0) ? ab : n + 1)) : 0;
      run_send(sel, c, ab, bs, 8'($urandom));
      idle_cycles(int'($urandom_range(0, 3)));
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
